// File: rtl/score_display_ctrl.sv
// Score readout controller: 8-bit binary score -> 3 BCD digits via a
// multi-cycle double-dabble engine, leading-zero blanking, and a 4-slot
// multiplexed seven-segment scan (digit 3 is always blank).
module score_display_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int NUM_AN   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        score,
    input  logic              score_valid,
    output logic              busy,
    output logic [NUM_AN-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  cap;        // value accepted for the conversion about to run
    logic        pend;       // a request arrived while busy
    logic [7:0]  pend_val;   // newest request seen while busy (last wins)
    logic [7:0]  shreg;      // binary bits still to be shifted in
    logic [11:0] scr;        // scratch {hund,tens,ones} during conversion
    logic [2:0]  bitcnt;
    logic [3:0]  hund, tens, ones;  // digits currently on display

    logic [PW-1:0] presc;
    logic [1:0]    idx;

    logic [11:0] adj;
    logic [6:0]  slot_seg;
    logic [NUM_AN-1:0] slot_an;

    // Decimal point is never used on the score readout.
    assign dp = 1'b1;

    // Add-3 correction for a BCD column before it is doubled.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}; anything above 9 is blank.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Per-iteration column correction of the scratch digits.
    always_comb begin
        adj = {add3(scr[11:8]), add3(scr[7:4]), add3(scr[3:0])};
    end

    // Conversion sequencer; also latches requests that arrive while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cap      <= 8'h00;
            pend     <= 1'b0;
            pend_val <= 8'h00;
            shreg    <= 8'h00;
            scr      <= 12'h000;
            bitcnt   <= 3'd0;
            hund     <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
        end else begin
            if (state != IDLE && score_valid) begin
                pend     <= 1'b1;
                pend_val <= score;
            end
            case (state)
                IDLE: begin
                    if (score_valid || pend) begin
                        cap   <= score_valid ? score : pend_val;
                        pend  <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    scr    <= 12'h000;
                    shreg  <= cap;
                    bitcnt <= 3'd0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {scr, shreg} <= {adj[10:0], shreg, 1'b0};
                    bitcnt       <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state <= COMMIT;
                end
                COMMIT: begin
                    // Digits swap together so the display never shows a mix.
                    {hund, tens, ones} <= scr;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pattern and anode for the slot currently selected by the scan index.
    always_comb begin
        slot_seg = 7'h7F;
        slot_an  = ~(NUM_AN'(1) << idx);
        case (idx)
            2'd0: slot_seg = enc(ones);
            2'd1: if (hund != 4'd0 || tens != 4'd0) slot_seg = enc(tens);
            2'd2: if (hund != 4'd0) slot_seg = enc(hund);
            default: slot_seg = 7'h7F;
        endcase
    end

    // Scan prescaler, slot index and registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= 2'd0;
            an    <= '1;
            seg   <= 7'h7F;
        end else begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            an  <= slot_an;
            seg <= slot_seg;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: stimulus pushes the expected
// slot patterns per request; a monitor pops one entry whenever busy falls,
// checks the busy length and then samples a full scan of the display.
module tb_score_display_ctrl;

    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] score = 8'h00;
    logic       score_valid = 1'b0;
    logic       busy, dp;
    logic [3:0] an;
    logic [6:0] seg;

    typedef struct {
        logic [6:0] s0, s1, s2;
        int         val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   last_gap = -1;

    score_display_ctrl #(.SCAN_DIV(SD), .NUM_AN(4)) dut (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, want);
    endtask

    // Monitor: busy-length measurement, scoreboard pop, scan sampling.
    int         hi_cnt = 0, lo_cnt = 0, coll = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] got[4];
    exp_t       cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt = 0; lo_cnt = 0; coll = 0; prev_busy = 1'b0;
        end else begin
            if (coll > 0) begin
                case (an)
                    4'b1110: got[0] = {1'b0, seg};
                    4'b1101: got[1] = {1'b0, seg};
                    4'b1011: got[2] = {1'b0, seg};
                    4'b0111: got[3] = {1'b0, seg};
                    default: chk("an_onehot_low", {28'h0, an}, 32'he);
                endcase
                coll--;
                if (coll == 0) begin
                    chk($sformatf("score%0d_ones", cur.val),  {24'h0, got[0]}, {25'h0, cur.s0});
                    chk($sformatf("score%0d_tens", cur.val),  {24'h0, got[1]}, {25'h0, cur.s1});
                    chk($sformatf("score%0d_hund", cur.val),  {24'h0, got[2]}, {25'h0, cur.s2});
                    chk($sformatf("score%0d_slot3", cur.val), {24'h0, got[3]}, 32'h7f);
                end
            end
            if (busy) begin
                if (!prev_busy) last_gap = lo_cnt;
                hi_cnt++;
            end else begin
                if (prev_busy) begin
                    chk("busy_len", hi_cnt, 10);
                    chk("commit_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        for (int i = 0; i < 4; i++) got[i] = 8'h80;
                        coll = 4 * SD;
                    end
                    hi_cnt = 0;
                    lo_cnt = 0;
                end
                lo_cnt++;
            end
            prev_busy = busy;
        end
    end

    // Drive one single-cycle request and record what the display should show.
    task automatic req(input int v, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input int settle);
        @(negedge clk);
        score = v[7:0];
        score_valid = 1'b1;
        exp_q.push_back('{s0: s0, s1: s1, s2: s2, val: v});
        @(negedge clk);
        score_valid = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    // Called at the negedge where reset is released: expect a "0" readout.
    task automatic scan_check(input string tag);
        for (int k = 1; k <= 4 * 4 * SD; k++) begin
            int slot;
            logic [3:0] ea;
            @(negedge clk);
            slot = ((k - 1) / SD) % 4;
            ea = 4'b1111 ^ (4'b0001 << slot);
            chk($sformatf("%s_an_k%0d", tag, k), {28'h0, an}, {28'h0, ea});
            chk($sformatf("%s_seg_k%0d", tag, k), {25'h0, seg}, (slot == 0) ? 32'h40 : 32'h7f);
        end
        chk($sformatf("%s_busy", tag), {31'h0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_an",   {28'h0, an}, 32'hf);
        chk("rst_seg",  {25'h0, seg}, 32'h7f);
        chk("rst_dp",   {31'h0, dp}, 1);
        rst_n = 1'b1;
        scan_check("por");

        req(42,  7'h24, 7'h19, 7'h7F, 25);
        req(255, 7'h12, 7'h12, 7'h24, 25);
        req(100, 7'h40, 7'h40, 7'h79, 25);
        req(7,   7'h78, 7'h7F, 7'h7F, 25);
        req(0,   7'h40, 7'h7F, 7'h7F, 25);

        // Requests while busy: 20 is superseded by 30.
        @(negedge clk);
        score = 8'd10; score_valid = 1'b1;
        exp_q.push_back('{s0: 7'h40, s1: 7'h79, s2: 7'h7F, val: 10});
        @(negedge clk); score_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); score = 8'd20; score_valid = 1'b1;
        @(negedge clk); score_valid = 1'b0;
        @(negedge clk); score = 8'd30; score_valid = 1'b1;
        exp_q.push_back('{s0: 7'h40, s1: 7'h30, s2: 7'h7F, val: 30});
        @(negedge clk); score_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_gap_between_conversions", last_gap, 1);

        // Reset in the middle of a conversion.
        req(99, 7'h10, 7'h10, 7'h7F, 25);
        @(negedge clk); score = 8'd200; score_valid = 1'b1;
        @(negedge clk); score_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_an",   {28'h0, an}, 32'hf);
        chk("arst_seg",  {25'h0, seg}, 32'h7f);
        chk("arst_dp",   {31'h0, dp}, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan_check("post_rst");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
